// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: it passes ALU results through, or runs one
// load/store on a single-outstanding bus with byte lanes and load extension.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_data,
    input  logic [4:0]  ex_rd_addr,
    input  logic [31:0] ex_pc_plus_4,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic        ex_write_from_pc,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_read_data,
    output logic [4:0]  mem_rd_addr,
    output logic [31:0] mem_pc_plus_4,
    output logic        mem_reg_write,
    output logic        mem_mem_to_reg,
    output logic        mem_write_from_pc,
    output logic        stall,
    output logic        misaligned
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;
    logic [31:0] rdata_q;

    logic        access;
    logic        is_half;
    logic        is_word;
    logic        mis;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    always_comb begin
        access  = ex_valid & (ex_mem_read | ex_mem_write);
        is_half = (ex_funct3[1:0] == 2'b01);
        is_word = ex_funct3[1];
        mis     = (is_half & ex_alu_result[0]) | (is_word & (|ex_alu_result[1:0]));
        case (ex_funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << ex_alu_result[1:0];
                wdata_calc = {4{ex_rs2_data[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << {ex_alu_result[1], 1'b0};
                wdata_calc = {2{ex_rs2_data[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = ex_rs2_data;
            end
        endcase
    end

    // Lane selection uses only the fields latched when the request was issued.
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_be    <= 4'd0;
            lane_q    <= 2'd0;
            funct3_q  <= 3'd0;
            rdata_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !mis) begin
                        state     <= REQ;
                        bus_req   <= 1'b1;
                        bus_we    <= ex_mem_write;
                        bus_addr  <= {ex_alu_result[31:2], 2'b00};
                        bus_wdata <= wdata_calc;
                        bus_be    <= be_calc;
                        lane_q    <= ex_alu_result[1:0];
                        funct3_q  <= ex_funct3;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        rdata_q <= load_ext;
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_alu_result    = ex_alu_result;
        mem_rd_addr       = ex_rd_addr;
        mem_pc_plus_4     = ex_pc_plus_4;
        mem_mem_to_reg    = ex_mem_to_reg;
        mem_write_from_pc = ex_write_from_pc;
        mem_read_data     = 32'd0;
        mem_reg_write     = 1'b0;
        stall             = 1'b0;
        misaligned        = 1'b0;
        case (state)
            IDLE: begin
                if (!access)
                    mem_reg_write = ex_reg_write & ex_valid;
                else if (mis)
                    misaligned = 1'b1;
                else
                    stall = 1'b1;
            end
            REQ:  stall = 1'b1;
            DONE: begin
                mem_reg_write = ex_reg_write;
                mem_read_data = bus_we ? 32'd0 : rdata_q;
            end
            default: stall = 1'b0;
        endcase
        // Reset blanks everything the next stage could latch.
        if (rst) begin
            mem_alu_result    = 32'd0;
            mem_rd_addr       = 5'd0;
            mem_pc_plus_4     = 32'd0;
            mem_mem_to_reg    = 1'b0;
            mem_write_from_pc = 1'b0;
            mem_read_data     = 32'd0;
            mem_reg_write     = 1'b0;
            stall             = 1'b0;
            misaligned        = 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver queues expected stage and bus
// results from an arithmetic model; independent monitors pop and compare.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_write_from_pc;
    logic [31:0] ex_alu_result, ex_rs2_data, ex_pc_plus_4;
    logic [4:0]  ex_rd_addr;
    logic [2:0]  ex_funct3;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic [31:0] mem_alu_result, mem_read_data, mem_pc_plus_4;
    logic [4:0]  mem_rd_addr;
    logic        mem_reg_write, mem_mem_to_reg, mem_write_from_pc, stall, misaligned;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
        .ex_rd_addr(ex_rd_addr), .ex_pc_plus_4(ex_pc_plus_4), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_write_from_pc(ex_write_from_pc),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
        .mem_rd_addr(mem_rd_addr), .mem_pc_plus_4(mem_pc_plus_4),
        .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_write_from_pc(mem_write_from_pc), .stall(stall), .misaligned(misaligned)
    );

    typedef struct {
        logic [31:0] alu, rdata, pc;
        logic [4:0]  rd;
        logic        rw, m2r, wfp, mis;
        int          stalls;
    } out_t;

    typedef struct {
        logic        we;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        int          cycles;
    } bus_t;

    out_t exp_q[$];
    bus_t bus_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   active   = 0;
    int   txn_no   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Stage-output monitor: one completion per non-stalled cycle.
    initial begin
        int   sc;
        int   bc;
        out_t e;
        bus_t b;
        sc = 0;
        bc = 0;
        forever begin
            @(negedge clk);
            if (rst || !active) begin
                sc = 0;
                bc = 0;
            end else begin
                if (bus_req) bc++;
                if (bus_req && bus_ack) begin
                    if (bus_q.size() == 0) chk("bus_unexpected", 1, 0);
                    else begin
                        b = bus_q.pop_front();
                        chk("bus_we", bus_we, b.we);
                        chk("bus_addr", bus_addr, b.addr);
                        chk("bus_be", bus_be, b.be);
                        chk("bus_wdata", bus_wdata, b.wdata);
                        chk("bus_req_cycles", bc, b.cycles);
                    end
                    bc = 0;
                end
                if (stall) begin
                    sc++;
                    chk("misaligned_in_stall", misaligned, 0);
                    chk("reg_write_in_stall", mem_reg_write, 0);
                end else if (exp_q.size() == 0) begin
                    chk("out_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mem_alu_result", mem_alu_result, e.alu);
                    chk("mem_read_data", mem_read_data, e.rdata);
                    chk("mem_rd_addr", mem_rd_addr, e.rd);
                    chk("mem_pc_plus_4", mem_pc_plus_4, e.pc);
                    chk("mem_reg_write", mem_reg_write, e.rw);
                    chk("mem_mem_to_reg", mem_mem_to_reg, e.m2r);
                    chk("mem_write_from_pc", mem_write_from_pc, e.wfp);
                    chk("misaligned", misaligned, e.mis);
                    chk("stall_cycles", sc, e.stalls);
                    chk("bus_req_at_completion", bus_req, 0);
                    $display("txn %0d addr=%h rdata=%h rw=%b mis=%b stalls=%0d",
                             txn_no, mem_alu_result, mem_read_data, mem_reg_write, misaligned, sc);
                    txn_no++;
                    sc = 0;
                end
            end
        end
    end

    // Issues one EX/MEM instruction, predicts its results, and acts as bus responder.
    task automatic txn(input logic v, input logic rd_, input logic wr_, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rdn,
                       input logic [31:0] pc, input logic rw, input logic m2r, input logic wfp,
                       input int waitn, input logic [31:0] rdata);
        out_t        e;
        bus_t        b;
        int          s;
        int          lane;
        int          reqc;
        int          guard;
        bit          acc;
        bit          done;
        longint      mask;
        longint      val;
        s    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        lane = int'(addr % 4);
        acc  = v && (rd_ || wr_);
        e.alu = addr; e.rd = rdn; e.pc = pc; e.m2r = m2r; e.wfp = wfp;
        e.rdata = 32'd0; e.mis = 1'b0; e.stalls = 0;
        if (!acc) begin
            e.rw = rw & v;
        end else if ((addr % s) != 0) begin
            e.rw  = 1'b0;
            e.mis = 1'b1;
        end else begin
            e.rw     = rw;
            e.stalls = 2 + waitn;
            b.we     = wr_;
            b.addr   = addr & 32'hFFFF_FFFC;
            b.be     = 4'(((1 << s) - 1) << lane);
            for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = rs2[8*(i % s) +: 8];
            b.cycles = waitn + 1;
            if (!wr_) begin
                mask = (64'd1 << (8 * s)) - 1;
                val  = (longint'(rdata) >> (8 * lane)) & mask;
                if (s < 4 && !f3[2] && val[8*s-1]) val = val | ~mask;
                e.rdata = val[31:0];
            end
            bus_q.push_back(b);
        end
        exp_q.push_back(e);
        ex_valid = v; ex_mem_read = rd_; ex_mem_write = wr_; ex_funct3 = f3;
        ex_alu_result = addr; ex_rs2_data = rs2; ex_rd_addr = rdn; ex_pc_plus_4 = pc;
        ex_reg_write = rw; ex_mem_to_reg = m2r; ex_write_from_pc = wfp; bus_rdata = rdata;
        reqc  = 0;
        guard = 0;
        forever begin
            bus_ack = bus_req ? (reqc == waitn) : 1'($urandom_range(0, 1));
            @(negedge clk);
            done = !stall;
            if (bus_req) reqc++;
            @(posedge clk);
            #1;
            if (done) break;
            guard++;
            if (guard > 20) begin
                chk("completion_timeout", 1, 0);
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'd0;
        ex_alu_result = 32'h1234; ex_rs2_data = 32'hDEAD_BEEF; ex_rd_addr = 5'd5;
        ex_pc_plus_4 = 32'h104; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b1; ex_write_from_pc = 1'b1;
        bus_rdata = 32'hFFFF_FFFF; bus_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_reg_write", mem_reg_write, 0);
        chk("rst_mem_alu_result", mem_alu_result, 0);
        chk("rst_mem_rd_addr", mem_rd_addr, 0);
        chk("rst_mem_pc_plus_4", mem_pc_plus_4, 0);
        chk("rst_mem_read_data", mem_read_data, 0);
        chk("rst_stall", stall, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        rst = 1'b0;
        bus_ack = 1'b0;
        active = 1'b1;

        txn(1, 0, 0, 3'b000, 32'h1234, 32'h0, 5'd5, 32'h200, 1, 0, 0, 0, 32'h0);          // ALU op
        txn(1, 1, 0, 3'b000, 32'h1003, 32'h0, 5'd7, 32'h204, 1, 1, 0, 0, 32'h80FF_FF7F);   // LB
        txn(1, 0, 1, 3'b001, 32'h2002, 32'hABCD_1234, 5'd0, 32'h208, 0, 0, 0, 2, 32'h0);   // SH
        txn(1, 1, 0, 3'b010, 32'h3001, 32'h0, 5'd1, 32'h20C, 1, 1, 0, 0, 32'h0);          // LW misaligned
        txn(1, 1, 0, 3'b101, 32'h4002, 32'h0, 5'd9, 32'h210, 1, 1, 0, 0, 32'hFEDC_0000);   // LHU
        txn(1, 1, 1, 3'b000, 32'h4001, 32'h0000_0055, 5'd3, 32'h214, 1, 0, 0, 1, 32'h0);   // read+write is a store
        txn(0, 1, 0, 3'b010, 32'h5000, 32'h0, 5'd4, 32'h218, 1, 0, 0, 0, 32'h0);          // bubble

        // Reset in the middle of a request.
        active = 1'b0;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'b010;
        ex_alu_result = 32'h5000; ex_reg_write = 1'b1; bus_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_req_bus_req", bus_req, 1);
        chk("mid_req_stall", stall, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_bus_req", bus_req, 0);
        chk("async_rst_stall", stall, 0);
        chk("async_rst_bus_addr", bus_addr, 0);
        chk("async_rst_reg_write", mem_reg_write, 0);
        bus_ack = 1'b1;
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("stale_ack_bus_req", bus_req, 0);
            chk("stale_ack_stall", stall, 0);
        end
        active = 1'b1;

        for (int n = 0; n < 150; n++) begin
            txn(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom);
        end

        @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("bus_q_drained", bus_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
